crc_stream_pipe: RTL
====================

CRC_STREAM_PIPE -- requirements
Module: crc_stream_pipe

Interface
REQ-001 P_WIDTH, 8, CRC register and polynomial width in bits.
REQ-002 P_POLYNOM, 8'h31, generator polynomial without the implicit top bit.
REQ-003 P_INIT, '0, CRC register value loaded at the start of every message.
REQ-004 P_XOR_OUT, '0, value XORed into the final CRC.
REQ-005 P_MSG_BITS, 8, message length in bits; one message per input beat.
REQ-006 P_BITS_PER_STAGE, 1, bits absorbed per pipeline stage; must divide P_MSG_BITS, else elaboration error.
REQ-007 P_REFLECT_IN, 0, 0 = in_data MSB processed first, 1 = LSB processed first.
REQ-008 P_REFLECT_OUT, 0, 1 = bit-reverse the CRC before the P_XOR_OUT step.
REQ-009 P_TAG_W, 4, width of the sideband tag carried with each message.
REQ-010 clk  input  1  single clock; all state updates on the rising edge.
REQ-011 rstN  input  1  asynchronous, active-low reset.
REQ-012 in_valid  input  1  in_data/in_tag hold a message.
REQ-013 in_ready  output  1  the block accepts the message this cycle.
REQ-014 in_data  input  P_MSG_BITS  message bits.
REQ-015 in_tag  input  P_TAG_W  sideband tag, passed through unchanged.
REQ-016 out_valid  output  1  out_crc/out_tag are valid.
REQ-017 out_ready  input  1  downstream accepts the result.
REQ-018 out_crc  output  P_WIDTH  finished CRC.
REQ-019 out_tag  output  P_TAG_W  tag of the message that produced out_crc.
REQ-020 busy  output  1  any pipeline stage holds a valid message.
REQ-021 msg_count  output  16  number of completed output handshakes, wrapping modulo 2^16.

Function
REQ-022 The block SHALL contain N = P_MSG_BITS/P_BITS_PER_STAGE registered stages, each holding a valid bit, a partial CRC, the remaining message bits and the tag.
REQ-023 Per absorbed bit b: fb = crc[P_WIDTH-1] ^ b; crc = crc << 1; if fb, crc ^= P_POLYNOM.
REQ-024 Stage 0 SHALL start from P_INIT; stage k SHALL absorb bits k*P_BITS_PER_STAGE .. (k+1)*P_BITS_PER_STAGE-1 of the processing order set by P_REFLECT_IN.
REQ-025 out_crc SHALL equal (P_REFLECT_OUT ? bitrev(crc_N) : crc_N) ^ P_XOR_OUT, driven from the last-stage register.
REQ-026 advance = !out_valid || out_ready; when advance, every stage SHALL load from its predecessor and stage 0 SHALL load from the input.
REQ-027 When advance is low, all stages SHALL hold their contents, including valid bits.
REQ-028 in_ready SHALL equal advance; a message is accepted only when in_valid && in_ready.
REQ-029 On an advance with no accepted input, stage 0 SHALL load valid=0 (a bubble); data in bubble stages is don't-care.
REQ-030 Latency SHALL be exactly N cycles from the accepting edge to out_valid=1 when out_ready stays high; throughput SHALL be one message per cycle.
REQ-031 While out_valid=1 and out_ready=0, out_crc and out_tag SHALL stay stable.
REQ-032 busy SHALL be the OR of all stage valid bits.
REQ-033 msg_count SHALL increment by 1 on each out_valid && out_ready edge and wrap from 16'hFFFF to 0.
REQ-034 An input accepted in the same cycle as an output handshake SHALL be processed normally; no message is lost or duplicated.

Reset
REQ-035 While rstN=0, all valid bits SHALL clear asynchronously; out_valid=0, busy=0, msg_count=0, out_crc='0, out_tag='0.
REQ-036 Reset asserted mid-operation SHALL discard every in-flight message; no partial result SHALL appear after release.
REQ-037 in_ready SHALL be 1 in the first cycle after rstN deasserts.

Verification
REQ-038 Defaults, in_data=8'h80, in_tag=4'h3, out_ready=1 -> out_valid 8 cycles later with out_crc=8'h7A, out_tag=4'h3.
REQ-039 Defaults, back-to-back in_data 8'h01, 8'h81, 8'h00 -> three consecutive results 8'h31, 8'h4B, 8'h00; msg_count=3.
REQ-040 Hold out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, out_crc stable; after release, all results arrive in order, none dropped.
REQ-041 Pulse rstN low for one cycle with 4 messages in flight -> busy=0, out_valid=0, and no stale outputs afterwards.
REQ-042 P_BITS_PER_STAGE=4 (N=2), in_data=8'h80 -> out_crc=8'h7A after 2 cycles.
REQ-043 Preload msg_count to 16'hFFFF (drive 65535 handshakes), then complete one more -> msg_count=16'h0000.

Source files
------------

// File: rtl/crc_stream_pipe.sv
// Bit-serial CRC unrolled into an N-stage pipeline, one message per beat.
// Each stage absorbs P_BITS_PER_STAGE message bits; whole pipe stalls on backpressure.
module crc_stream_pipe #(
  parameter int                 P_WIDTH          = 8,
  parameter logic [P_WIDTH-1:0] P_POLYNOM        = 8'h31,
  parameter logic [P_WIDTH-1:0] P_INIT           = '0,
  parameter logic [P_WIDTH-1:0] P_XOR_OUT        = '0,
  parameter int                 P_MSG_BITS       = 8,
  parameter int                 P_BITS_PER_STAGE = 1,
  parameter bit                 P_REFLECT_IN     = 1'b0,
  parameter bit                 P_REFLECT_OUT    = 1'b0,
  parameter int                 P_TAG_W          = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [P_MSG_BITS-1:0] in_data,
  input  logic [P_TAG_W-1:0]    in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [P_WIDTH-1:0]    out_crc,
  output logic [P_TAG_W-1:0]    out_tag,
  output logic                  busy,
  output logic [15:0]           msg_count
);

  localparam int N = P_MSG_BITS / P_BITS_PER_STAGE;
  localparam int B = P_BITS_PER_STAGE;

  if (P_MSG_BITS % P_BITS_PER_STAGE != 0) begin : g_bad_split
    $error("P_BITS_PER_STAGE must divide P_MSG_BITS");
  end

  function automatic logic [P_WIDTH-1:0] absorb(
    input logic [P_WIDTH-1:0]    c,
    input logic [P_MSG_BITS-1:0] m
  );
    logic [P_WIDTH-1:0] r;
    logic               fb;
    r = c;
    for (int i = 0; i < B; i++) begin
      fb = r[P_WIDTH-1] ^ m[P_MSG_BITS-1-i];
      r  = r << 1;
      if (fb) r = r ^ P_POLYNOM;
    end
    return r;
  endfunction

  function automatic logic [P_MSG_BITS-1:0] rev_msg(
    input logic [P_MSG_BITS-1:0] m
  );
    logic [P_MSG_BITS-1:0] r;
    for (int i = 0; i < P_MSG_BITS; i++)
      r[i] = m[P_MSG_BITS-1-i];
    return r;
  endfunction

  function automatic logic [P_WIDTH-1:0] rev_crc(
    input logic [P_WIDTH-1:0] c
  );
    logic [P_WIDTH-1:0] r;
    for (int i = 0; i < P_WIDTH; i++)
      r[i] = c[P_WIDTH-1-i];
    return r;
  endfunction

  logic [N-1:0]          vld_q;
  logic [P_WIDTH-1:0]    crc_q [N];
  logic [P_WIDTH-1:0]    crc_d [N];
  logic [P_MSG_BITS-1:0] msg_q [N];
  logic [P_MSG_BITS-1:0] msg_d [N];
  logic [P_TAG_W-1:0]    tag_q [N];
  logic [15:0]           cnt_q;
  logic [15:0]           cnt_d;

  logic                  advance;
  logic                  accept;
  logic                  out_hs;
  logic [P_MSG_BITS-1:0] msg_in;
  logic [P_WIDTH-1:0]    fin_crc;

  assign out_valid = vld_q[N-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_hs    = out_valid && out_ready;
  assign busy      = |vld_q;
  assign msg_count = cnt_q;

  // Normalise so every stage consumes from the MSB end.
  assign msg_in = P_REFLECT_IN ? rev_msg(in_data) : in_data;

  always_comb begin
    crc_d[0] = absorb(P_INIT, msg_in);
    msg_d[0] = msg_in << B;
    for (int k = 1; k < N; k++) begin
      crc_d[k] = absorb(crc_q[k-1], msg_q[k-1]);
      msg_d[k] = msg_q[k-1] << B;
    end
  end

  assign cnt_d = out_hs ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < N; k++) begin
        crc_q[k] <= '0;
        msg_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (advance) begin
        vld_q[0] <= accept;
        crc_q[0] <= crc_d[0];
        msg_q[0] <= msg_d[0];
        tag_q[0] <= in_tag;
        for (int k = 1; k < N; k++) begin
          vld_q[k] <= vld_q[k-1];
          crc_q[k] <= crc_d[k];
          msg_q[k] <= msg_d[k];
          tag_q[k] <= tag_q[k-1];
        end
      end
    end
  end

  assign fin_crc = P_REFLECT_OUT ? rev_crc(crc_q[N-1])
                                 : crc_q[N-1];

  // Outputs read zero whenever the last stage is empty.
  assign out_crc = out_valid ? (fin_crc ^ P_XOR_OUT) : '0;
  assign out_tag = out_valid ? tag_q[N-1] : '0;

endmodule
